// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: bubble insertion on hazards/flush, operand forwarding into EX.
// Build option: define FORWARDING_EN for EX/MEM + MEM/WB forwarding (load-use-only stalls).
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        id_alu_src,
  input  logic [3:0]  id_acl,
  input  logic        id_activate_mul_module,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        flush,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_reg_write,
  input  logic [31:0] ex_mem_result,
  input  logic [4:0]  mem_wb_rd,
  input  logic        mem_wb_reg_write,
  input  logic [31:0] mem_wb_data,
  output logic        stall,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_a,
  output logic [31:0] id_ex_b,
  output logic [3:0]  id_ex_acl,
  output logic        id_ex_activate_mul_module,
  output logic [4:0]  id_ex_rd,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic [31:0] id_ex_store_data
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        alu_src;
    logic [3:0]  acl;
    logic        mul;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } id_ex_t;

  id_ex_t      id_ex_d, id_ex_q;
  logic        rs2_used;
  logic        hazard;
  logic [31:0] rs1_fwd, rs2_fwd;

  // True when a writer of register rd (non-x0) produces a source the ID instruction reads.
  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic used2);
    return (rd != 5'd0) && ((rd == rs1) || (used2 && (rd == rs2)));
  endfunction

  assign rs2_used = ~id_alu_src | id_mem_write;

`ifdef FORWARDING_EN
  assign hazard = id_ex_q.valid & id_ex_q.mem_read &
                  rd_hit(id_ex_q.rd, id_rs1, id_rs2, rs2_used);
`else
  assign hazard = (id_ex_q.valid & id_ex_q.reg_write &
                   rd_hit(id_ex_q.rd, id_rs1, id_rs2, rs2_used)) |
                  (ex_mem_reg_write & rd_hit(ex_mem_rd, id_rs1, id_rs2, rs2_used)) |
                  (mem_wb_reg_write & rd_hit(mem_wb_rd, id_rs1, id_rs2, rs2_used));

  logic unused_fwd;
  assign unused_fwd = ^{ex_mem_result, mem_wb_data, id_ex_q.rs1, id_ex_q.rs2};
`endif

  assign stall = hazard & ~flush & if_id_valid;

  always_comb begin
    id_ex_d = '0;
    if (!(flush || stall)) begin
      id_ex_d.valid     = if_id_valid;
      id_ex_d.rs1       = id_rs1;
      id_ex_d.rs2       = id_rs2;
      id_ex_d.rd        = id_rd;
      id_ex_d.rs1_data  = id_rs1_data;
      id_ex_d.rs2_data  = id_rs2_data;
      id_ex_d.imm       = id_imm;
      id_ex_d.alu_src   = id_alu_src;
      id_ex_d.acl       = id_acl;
      id_ex_d.mul       = id_activate_mul_module;
      id_ex_d.reg_write = id_reg_write;
      id_ex_d.mem_read  = id_mem_read;
      id_ex_d.mem_write = id_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  // EX/MEM is the younger result, so it takes priority over MEM/WB.
  always_comb begin
    rs1_fwd = id_ex_q.rs1_data;
    rs2_fwd = id_ex_q.rs2_data;
`ifdef FORWARDING_EN
    if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_q.rs1)) begin
      rs1_fwd = ex_mem_result;
    end else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_q.rs1)) begin
      rs1_fwd = mem_wb_data;
    end
    if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_q.rs2)) begin
      rs2_fwd = ex_mem_result;
    end else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_q.rs2)) begin
      rs2_fwd = mem_wb_data;
    end
`endif
  end

  assign id_ex_valid               = id_ex_q.valid;
  assign id_ex_a                   = rs1_fwd;
  assign id_ex_b                   = id_ex_q.alu_src ? id_ex_q.imm : rs2_fwd;
  assign id_ex_store_data          = rs2_fwd;
  assign id_ex_acl                 = id_ex_q.acl;
  assign id_ex_activate_mul_module = id_ex_q.mul;
  assign id_ex_rd                  = id_ex_q.rd;
  assign id_ex_reg_write           = id_ex_q.reg_write;
  assign id_ex_mem_read            = id_ex_q.mem_read;
  assign id_ex_mem_write           = id_ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected EX-stage outputs, a negedge
// monitor pops one entry per valid EX instruction. Stall/bubble/reset are checked inline.
module tb_id_ex_stage;

`ifdef FORWARDING_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_acl;
  logic        id_activate_mul_module, id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic [4:0]  ex_mem_rd, mem_wb_rd;
  logic        ex_mem_reg_write, mem_wb_reg_write;
  logic [31:0] ex_mem_result, mem_wb_data;
  logic        stall, id_ex_valid;
  logic [31:0] id_ex_a, id_ex_b, id_ex_store_data;
  logic [3:0]  id_ex_acl;
  logic        id_ex_activate_mul_module;
  logic [4:0]  id_ex_rd;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;

  id_ex_stage dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .if_id_valid               (if_id_valid),
    .id_rs1                    (id_rs1),
    .id_rs2                    (id_rs2),
    .id_rd                     (id_rd),
    .id_rs1_data               (id_rs1_data),
    .id_rs2_data               (id_rs2_data),
    .id_imm                    (id_imm),
    .id_alu_src                (id_alu_src),
    .id_acl                    (id_acl),
    .id_activate_mul_module    (id_activate_mul_module),
    .id_reg_write              (id_reg_write),
    .id_mem_read               (id_mem_read),
    .id_mem_write              (id_mem_write),
    .flush                     (flush),
    .ex_mem_rd                 (ex_mem_rd),
    .ex_mem_reg_write          (ex_mem_reg_write),
    .ex_mem_result             (ex_mem_result),
    .mem_wb_rd                 (mem_wb_rd),
    .mem_wb_reg_write          (mem_wb_reg_write),
    .mem_wb_data               (mem_wb_data),
    .stall                     (stall),
    .id_ex_valid               (id_ex_valid),
    .id_ex_a                   (id_ex_a),
    .id_ex_b                   (id_ex_b),
    .id_ex_acl                 (id_ex_acl),
    .id_ex_activate_mul_module (id_ex_activate_mul_module),
    .id_ex_rd                  (id_ex_rd),
    .id_ex_reg_write           (id_ex_reg_write),
    .id_ex_mem_read            (id_ex_mem_read),
    .id_ex_mem_write           (id_ex_mem_write),
    .id_ex_store_data          (id_ex_store_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [3:0]  acl;
    logic        mul;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic push(input string tag, input logic [31:0] a, b, sd, input logic [4:0] rd,
                      input logic [3:0] acl, input logic mul, rw, mr, mw);
    exp_t e;
    e = '{a: a, b: b, sd: sd, rd: rd, acl: acl, mul: mul, rw: rw, mr: mr, mw: mw};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (rst_n && id_ex_valid) begin
      exp_t  act, e;
      string t;
      act = '{a: id_ex_a, b: id_ex_b, sd: id_ex_store_data, rd: id_ex_rd, acl: id_ex_acl,
              mul: id_ex_activate_mul_module, rw: id_ex_reg_write, mr: id_ex_mem_read,
              mw: id_ex_mem_write};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got valid EX instr a=%h rd=%0d, expected none",
                 act.a, act.rd);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got a=%h b=%h sd=%h rd=%0d acl=%h mul/rw/mr/mw=%b%b%b%b, expected a=%h b=%h sd=%h rd=%0d acl=%h mul/rw/mr/mw=%b%b%b%b",
                   t, act.a, act.b, act.sd, act.rd, act.acl, act.mul, act.rw, act.mr, act.mw,
                   e.a, e.b, e.sd, e.rd, e.acl, e.mul, e.rw, e.mr, e.mw);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic id_set(input logic [4:0] rs1, rs2, rd, input logic [31:0] d1, d2, imm,
                        input logic src, input logic [3:0] acl, input logic mul, rw, mr, mw);
    if_id_valid = 1'b1;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_alu_src = src; id_acl = acl; id_activate_mul_module = mul;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic id_idle();
    id_set(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    if_id_valid = 1'b0;
  endtask

  task automatic fwd(input logic [4:0] er, input logic ew, input logic [31:0] ed,
                     input logic [4:0] wr, input logic ww, input logic [31:0] wd);
    ex_mem_rd = er; ex_mem_reg_write = ew; ex_mem_result = ed;
    mem_wb_rd = wr; mem_wb_reg_write = ww; mem_wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_valid"}, {31'h0, id_ex_valid}, 32'h0);
    chk({pfx, "_stall"}, {31'h0, stall}, 32'h0);
    chk({pfx, "_ctl"}, {27'h0, id_ex_activate_mul_module, id_ex_reg_write, id_ex_mem_read,
                        id_ex_mem_write, 1'b0}, 32'h0);
    chk({pfx, "_acl_rd"}, {23'h0, id_ex_acl, id_ex_rd}, 32'h0);
    chk({pfx, "_a"}, id_ex_a, 32'h0);
    chk({pfx, "_b"}, id_ex_b, 32'h0);
    chk({pfx, "_sd"}, id_ex_store_data, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    id_idle();
    fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    #2;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // add x3,x1,x2; during its EX cycle EX/MEM writes x1 and MEM/WB writes x2
    id_set(5'd1, 5'd2, 5'd3, 32'h100, 32'h23, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("add_stall", {31'h0, stall}, 32'h0);
    push("add_fwd_both", Fwd ? 32'hBAD0_0001 : 32'h100, Fwd ? 32'hBAD0_0002 : 32'h23,
         Fwd ? 32'hBAD0_0002 : 32'h23, 5'd3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    fwd(5'd1, 1'b1, 32'hBAD0_0001, 5'd2, 1'b1, 32'hBAD0_0002);
    // addi x10,x11,-4: immediate on b, rs2 data still reaches store_data
    id_set(5'd11, 5'd12, 5'd10, 32'h7, 32'h55, 32'hFFFF_FFFC, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("addi_stall", {31'h0, stall}, 32'h0);
    push("addi_imm", 32'h7, 32'hFFFF_FFFC, 32'h55, 5'd10, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    // mul x15,x16,x17
    id_set(5'd16, 5'd17, 5'd15, 32'h1234, 32'h10, 32'h0, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
    push("mul_sel", 32'h1234, 32'h10, 32'h10, 5'd15, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    // sw x18,12(x19); EX/MEM rewrites x18 during its EX cycle
    id_set(5'd19, 5'd18, 5'd0, 32'h2000, 32'hCAFE_F00D, 32'hC, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("sw_stall", {31'h0, stall}, 32'h0);
    push("sw_store_data", 32'h2000, 32'hC, Fwd ? 32'h0BAD_F00D : 32'hCAFE_F00D, 5'd0, 4'h0,
         1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    fwd(5'd18, 1'b1, 32'h0BAD_F00D, 5'd0, 1'b0, 32'h0);
    id_idle();
    tick();
    fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

    // Priority: EX/MEM and MEM/WB both write x7; consumer of x7 then consumers of x0, x24
    id_set(5'd7, 5'd0, 5'd20, 32'h33, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("prio_x7", Fwd ? 32'h11 : 32'h33, 32'h0, 32'h0, 5'd20, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    fwd(5'd7, 1'b1, 32'h11, 5'd7, 1'b1, 32'h22);
    id_set(5'd0, 5'd0, 5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("x0_stall", {31'h0, stall}, 32'h0);
    push("x0_never_fwd", 32'h0, 32'h0, 32'h0, 5'd21, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    fwd(5'd0, 1'b1, 32'h44, 5'd0, 1'b1, 32'h55);
    id_set(5'd23, 5'd24, 5'd22, 32'h70, 32'h77, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("wb_stall", {31'h0, stall}, 32'h0);
    push("memwb_only", 32'h70, Fwd ? 32'h66 : 32'h77, Fwd ? 32'h66 : 32'h77, 5'd22, 4'h0,
         1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    fwd(5'd23, 1'b0, 32'h99, 5'd24, 1'b1, 32'h66);
    id_idle();
    tick();
    fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

    // Flush coincident with a load-use hazard
    id_set(5'd1, 5'd0, 5'd5, 32'h400, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    push("lw_pre_flush", 32'h400, 32'h0, 32'h0, 5'd5, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_set(5'd5, 5'd2, 5'd6, 32'h0, 32'h3, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1 chk("flush_stall", {31'h0, stall}, 32'h0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", {29'h0, id_ex_valid, id_ex_reg_write, id_ex_mem_read}, 32'h0);
    id_set(5'd13, 5'd14, 5'd12, 32'hF0, 32'h0F, 32'h0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("post_flush_stall", {31'h0, stall}, 32'h0);
    push("post_flush_or", 32'hF0, 32'h0F, 32'h0F, 5'd12, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_idle();
    tick();

`ifdef FORWARDING_EN
    // add x3,x1,x2 ; sub x4,x3,x1 forwarded from EX/MEM without stalling
    id_set(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("fw_add", 32'h1, 32'h2, 32'h2, 5'd3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_set(5'd3, 5'd1, 5'd4, 32'h0, 32'h100, 32'h0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("fw_sub_stall", {31'h0, stall}, 32'h0);
    push("fw_sub", 32'h10, 32'h100, 32'h100, 5'd4, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    fwd(5'd3, 1'b1, 32'h10, 5'd0, 1'b0, 32'h0);
    id_idle();
    tick();
    fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    // lw x5,0(x1) ; add x6,x5,x2: one bubble then MEM/WB forwarding
    id_set(5'd1, 5'd0, 5'd5, 32'h400, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    push("lu_lw", 32'h400, 32'h0, 32'h0, 5'd5, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_set(5'd5, 5'd2, 5'd6, 32'h0, 32'h3, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_stall_1", {31'h0, stall}, 32'h1);
    tick();
    fwd(5'd5, 1'b1, 32'h400, 5'd0, 1'b0, 32'h0);
    chk("lu_bubble", {31'h0, id_ex_valid}, 32'h0);
    #1 chk("lu_stall_2", {31'h0, stall}, 32'h0);
    push("lu_add", 32'hDEAD_BEEF, 32'h3, 32'h3, 5'd6, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    fwd(5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'hDEAD_BEEF);
    id_idle();
    tick();
    fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
`else
    // addi x8,x0,5 ; add x9,x8,x8 stalls through ID/EX, EX/MEM and MEM/WB
    id_set(5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h5, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("nf_addi", 32'h0, 32'h5, 32'h0, 5'd8, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_set(5'd8, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("nf_stall_1", {31'h0, stall}, 32'h1);
    tick();
    fwd(5'd8, 1'b1, 32'h5, 5'd0, 1'b0, 32'h0);
    chk("nf_bubble_1", {31'h0, id_ex_valid}, 32'h0);
    #1 chk("nf_stall_2", {31'h0, stall}, 32'h1);
    tick();
    fwd(5'd0, 1'b0, 32'h0, 5'd8, 1'b1, 32'h5);
    chk("nf_bubble_2", {31'h0, id_ex_valid}, 32'h0);
    #1 chk("nf_stall_3", {31'h0, stall}, 32'h1);
    tick();
    fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    id_set(5'd8, 5'd8, 5'd9, 32'h5, 32'h5, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("nf_bubble_3", {31'h0, id_ex_valid}, 32'h0);
    #1 chk("nf_stall_clear", {31'h0, stall}, 32'h0);
    push("nf_add", 32'h5, 32'h5, 32'h5, 5'd9, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_idle();
    tick();
`endif

    // Asynchronous reset in the middle of a load-use stall
    id_set(5'd1, 5'd0, 5'd5, 32'h400, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    push("rst_lw", 32'h400, 32'h0, 32'h0, 5'd5, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_set(5'd5, 5'd2, 5'd6, 32'h0, 32'h3, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("rst_pre_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("midrst");
    id_idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
